// File: rtl/knn_pkg.sv
// Shared definitions for the KNN bus master.
// Register map, FSM encoding and point field helpers.
package knn_pkg;

    localparam int A_RESET = 0;
    localparam int A_DATA1 = 1;
    localparam int A_DATA2 = 2;
    localparam int A_SEL   = 3;
    localparam int A_DONE  = 4;
    localparam int A_DOUT  = 5;

    localparam int PT_F_W  = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST1,
        S_RST0,
        S_D1,
        S_D2,
        S_POLL,
        S_SEL,
        S_RD,
        S_OUT,
        S_FIN
    } state_t;

    function automatic logic [PT_F_W-1:0] pt_x(input logic [31:0] p);
        return p[15:0];
    endfunction

    function automatic logic [PT_F_W-1:0] pt_y(input logic [31:0] p);
        return p[31:16];
    endfunction

endpackage

// File: rtl/knn_bus_if.sv
// Single-outstanding native-bus access engine.
// Holds a request until m_ready, then idles one cycle.
module knn_bus_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    // A request is only taken while idle; the cycle after
    // completion has m_valid low, which forms the idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
        end else if (m_valid) begin
            if (m_ready) m_valid <= 1'b0;
        end else if (req) begin
            m_valid   <= 1'b1;
            m_address <= addr;
            m_wdata   <= wdata;
            m_wstrb   <= we ? '1 : '0;
        end
    end

    assign busy  = m_valid;
    assign ack   = m_valid & m_ready;
    assign rdata = m_rdata;

endmodule

// File: rtl/knn_bus_master.sv
// KNN accelerator bus master: loads points, polls DONE,
// reads back HW_K neighbour results onto a stream.
module knn_bus_master
    import knn_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int HW_K    = 10,
    parameter int N_W     = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             test_pt,
    input  logic [N_W-1:0]          n_train,
    input  logic                    pt_valid,
    input  logic [31:0]             pt_data,
    output logic                    pt_ready,
    output logic                    res_valid,
    output logic [DATA_W-1:0]       res_data,
    output logic [$clog2(HW_K)-1:0] res_idx,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    m_valid,
    output logic [ADDR_W-1:0]       m_address,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_ready
);

    localparam int IW = $clog2(HW_K);
    localparam int PW = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    logic [31:0]       tpt;
    logic [N_W-1:0]    ntr, cnt;
    logic [PW-1:0]     poll_cnt;
    logic [IW-1:0]     idx;

    logic              req, we, bus_busy, ack;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              cnt_last, poll_last, idx_last;

    assign cnt_last  = cnt == ntr - N_W'(1);
    assign poll_last = poll_cnt == PW'(TIMEOUT - 1);
    assign idx_last  = idx == IW'(HW_K - 1);

    knn_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (bus_busy),
        .ack       (ack),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and the bus request of the current step.
    always_comb begin
        state_n  = state;
        req      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        pt_ready = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_n = S_RST1;
            S_RST1: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = ADDR_W'(A_RESET);
                wdata = DATA_W'(1);
                if (ack) state_n = S_RST0;
            end
            S_RST0: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = ADDR_W'(A_RESET);
                if (ack) state_n = S_D1;
            end
            S_D1: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = ADDR_W'(A_DATA1);
                wdata = DATA_W'(tpt);
                if (ack) state_n = (ntr != '0) ? S_D2 : S_POLL;
            end
            S_D2: begin
                req      = pt_valid;
                we       = 1'b1;
                addr     = ADDR_W'(A_DATA2);
                wdata    = DATA_W'(pt_data);
                pt_ready = pt_valid & ~bus_busy;
                if (ack && cnt_last) state_n = S_POLL;
            end
            S_POLL: begin
                req  = 1'b1;
                addr = ADDR_W'(A_DONE);
                if (ack) begin
                    if (rdata[0])       state_n = S_SEL;
                    else if (poll_last) state_n = S_FIN;
                end
            end
            S_SEL: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = ADDR_W'(A_SEL);
                wdata = DATA_W'(idx);
                if (ack) state_n = S_RD;
            end
            S_RD: begin
                req  = 1'b1;
                addr = ADDR_W'(A_DOUT);
                if (ack) state_n = S_OUT;
            end
            S_OUT: begin
                if (res_ready) state_n = idx_last ? S_FIN : S_SEL;
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Job parameters, counters, result register and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpt      <= '0;
            ntr      <= '0;
            cnt      <= '0;
            poll_cnt <= '0;
            idx      <= '0;
            res_data <= '0;
            res_idx  <= '0;
            error    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                tpt      <= test_pt;
                ntr      <= n_train;
                cnt      <= '0;
                poll_cnt <= '0;
                idx      <= '0;
                error    <= 1'b0;
            end
        end else if (state == S_D2) begin
            if (ack) cnt <= cnt + N_W'(1);
        end else if (state == S_POLL) begin
            if (ack && !rdata[0]) begin
                poll_cnt <= poll_cnt + PW'(1);
                if (poll_last) error <= 1'b1;
            end
        end else if (state == S_RD) begin
            if (ack) begin
                res_data <= rdata;
                res_idx  <= idx;
            end
        end else if (state == S_OUT) begin
            if (res_ready && !idx_last) idx <= idx + IW'(1);
        end
    end

    assign res_valid = state == S_OUT;
    assign done      = state == S_FIN;
    assign busy      = (state != S_IDLE) && (state != S_FIN);

endmodule

// File: tb/tb_knn_bus_master.sv
// Directed bench for knn_bus_master with a behavioural
// KNN slave, a point source and a result monitor.
module tb_knn_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] test_pt = '0;
    logic [15:0] n_train = '0;
    logic        pt_valid = 1'b0;
    logic [31:0] pt_data = '0;
    logic        pt_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic [0:0]  res_idx;
    logic        res_ready = 1'b1;
    logic        busy, done, error;
    logic        m_valid;
    logic [3:0]  m_address;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    int rdly = 1;
    bit gap = 0;
    bit done_val = 1;
    int done_cnt = 0;

    logic [31:0] pts[$];
    logic [63:0] log_q[$];
    logic [63:0] exp_log[$];
    logic [63:0] res_q[$];
    logic [63:0] exp_res[$];

    knn_bus_master #(.HW_K(2), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .test_pt   (test_pt),
        .n_train   (n_train),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_ready  (pt_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .m_valid   (m_valid),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ent(input bit w, input int a,
                                        input logic [31:0] d);
        logic [3:0] a4;
        a4 = a[3:0];
        return {27'b0, w, a4, d};
    endfunction

    // Behavioural KNN slave: m_ready after rdly cycles, logs accesses.
    int          wcnt = 0;
    logic [31:0] sel = '0;
    logic [35:0] snap;
    always @(negedge clk) begin
        if (rst) begin
            m_ready = 1'b0;
            wcnt = 0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            wcnt = 0;
        end else if (m_valid) begin
            wcnt++;
            if (wcnt == 1) snap = {m_address, m_wdata};
            else chk("stable", 64'({m_address, m_wdata}), 64'(snap));
            if (wcnt > rdly) begin
                m_ready = 1'b1;
                if (m_wstrb != 0) begin
                    log_q.push_back(ent(1, int'(m_address), m_wdata));
                    if (m_address == 3) sel = m_wdata;
                    m_rdata = '0;
                end else begin
                    log_q.push_back(ent(0, int'(m_address), 0));
                    if (m_address == 4) m_rdata = {31'b0, done_val};
                    else if (m_address == 5) m_rdata = 32'h11 * (sel + 1);
                    else m_rdata = '0;
                end
            end
        end
    end

    // Training point source, optionally valid every other cycle.
    int pcyc = 0;
    always @(negedge clk) begin
        pcyc++;
        pt_valid = (pts.size() > 0) && (!gap || pcyc[0]);
        pt_data = (pts.size() > 0) ? pts[0] : '0;
        #1;
        if (pt_valid && pt_ready) void'(pts.pop_front());
    end

    // Result stream and done pulse monitor.
    always @(negedge clk) begin
        #3;
        if (res_valid && res_ready)
            res_q.push_back({32'(res_idx), res_data});
        if (done) done_cnt++;
    end

    task automatic start_job(input logic [31:0] tp, input int n);
        log_q.delete();
        res_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        test_pt = tp;
        n_train = 16'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 500) begin
            @(negedge clk);
            #2;
            cyc++;
            if (done) break;
        end
        chk("done_seen", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_cnt", 64'(done_cnt), 64'd1);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_nlog"}, 64'(log_q.size()), 64'(exp_log.size()));
        foreach (exp_log[i])
            if (i < log_q.size())
                chk($sformatf("%s_acc%0d", tag, i), log_q[i], exp_log[i]);
    endtask

    task automatic cmp_res(input string tag);
        chk({tag, "_nres"}, 64'(res_q.size()), 64'(exp_res.size()));
        foreach (exp_res[i])
            if (i < res_q.size())
                chk($sformatf("%s_res%0d", tag, i), res_q[i], exp_res[i]);
    endtask

    task automatic exp_head(input logic [31:0] tp);
        exp_log.delete();
        exp_log.push_back(ent(1, 0, 1));
        exp_log.push_back(ent(1, 0, 0));
        exp_log.push_back(ent(1, 1, tp));
    endtask

    task automatic exp_tail();
        exp_log.push_back(ent(0, 4, 0));
        exp_log.push_back(ent(1, 3, 0));
        exp_log.push_back(ent(0, 5, 0));
        exp_log.push_back(ent(1, 3, 1));
        exp_log.push_back(ent(0, 5, 0));
        exp_res.delete();
        exp_res.push_back({32'd0, 32'h11});
        exp_res.push_back({32'd1, 32'h22});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},
            64'({pt_ready, res_valid, busy, done, error,
                 m_valid, m_wstrb, m_address, res_idx}), 64'd0);
        chk({tag, "_dat"}, {m_wdata, res_data}, 64'd0);
    endtask

    task automatic job_basic(input string tag);
        int cyc;
        pts.delete();
        pts.push_back(32'h0001_0001);
        pts.push_back(32'h0005_0005);
        pts.push_back(32'h0009_0009);
        start_job(32'h0003_0002, 2);
        wait_done(cyc);
        exp_head(32'h0003_0002);
        exp_log.push_back(ent(1, 2, 32'h0001_0001));
        exp_log.push_back(ent(1, 2, 32'h0005_0005));
        exp_tail();
        cmp_log(tag);
        cmp_res(tag);
        chk({tag, "_left"}, 64'(pts.size()), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset with a point waiting on the stream.
        pts.push_back(32'h0000_0007);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            chk_zero($sformatf("idle%0d", i));
        end
        chk("idle_nlog", 64'(log_q.size()), 64'd0);
        chk("idle_left", 64'(pts.size()), 64'd1);

        // Basic job, with one excess point left on the stream.
        job_basic("job1");

        // Empty training set: check end-to-end latency.
        pts.delete();
        start_job(32'h1234_5678, 0);
        wait_done(cyc);
        chk("lat_n0", 64'(cyc), 64'd26);
        exp_head(32'h1234_5678);
        exp_tail();
        cmp_log("n0");
        cmp_res("n0");

        // Gapped stream with slow bus completion.
        rdly = 3;
        gap = 1;
        pts.push_back(32'h000A_000B);
        pts.push_back(32'h000C_000D);
        pts.push_back(32'h000E_000F);
        start_job(32'h0007_0008, 3);
        wait_done(cyc);
        exp_head(32'h0007_0008);
        exp_log.push_back(ent(1, 2, 32'h000A_000B));
        exp_log.push_back(ent(1, 2, 32'h000C_000D));
        exp_log.push_back(ent(1, 2, 32'h000E_000F));
        exp_tail();
        cmp_log("gap");
        cmp_res("gap");
        chk("gap_left", 64'(pts.size()), 64'd0);
        rdly = 1;
        gap = 0;

        // DONE never set: poll timeout.
        done_val = 0;
        start_job(32'h00AA_00BB, 0);
        wait_done(cyc);
        exp_head(32'h00AA_00BB);
        repeat (8) exp_log.push_back(ent(0, 4, 0));
        cmp_log("tmo");
        chk("tmo_err", 64'(error), 64'd1);
        chk("tmo_nres", 64'(res_q.size()), 64'd0);

        // Result back-pressure, start while busy, error clears.
        done_val = 1;
        res_ready = 1'b0;
        start_job(32'h0004_0004, 0);
        #2;
        chk("err_clr", 64'(error), 64'd0);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("out_seen", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 1);
            test_pt = 32'hDEAD_BEEF;
            #2;
            chk($sformatf("stall_v%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("stall_d%0d", i),
                {32'(res_idx), res_data}, {32'd0, 32'h11});
            chk($sformatf("stall_bus%0d", i), 64'(m_valid), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        res_ready = 1'b1;
        wait_done(cyc);
        exp_head(32'h0004_0004);
        exp_tail();
        cmp_log("stall");
        cmp_res("stall");

        // Reset in the middle of loading training points.
        pts.delete();
        pts.push_back(32'h0002_0002);
        pts.push_back(32'h0003_0003);
        pts.push_back(32'h0004_0004);
        start_job(32'h0001_0001, 3);
        cyc = 0;
        while (log_q.size() < 4 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("rst_wait", 64'(log_q.size()), 64'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk_zero("postrst");
        job_basic("rerun");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
